cov_stream_accumulate: RTL
==========================

// Module: cov_stream_accumulate
// PURPOSE
// Streaming, parametrised covariance front end for the whitening chain. Accepts one multi-channel
// sample vector per handshake beat, accumulates first- and second-order sums over 2**LOG2_SAMPLES
// beats, then sequentially produces the exact integer matrix N*Sigma = N*S2 - S1*S1^T
// (N times the centered covariance). It replaces the fully combinational center/transpose/multiply
// path. Its output feeds the to_double conversion and the eigenvalue decomposition stages.
// PARAMETERS
// N_CH          8   number of channels (matrix rows); >= 1
// N_BITS        22  signed sample width
// LOG2_SAMPLES  7   log2 of samples per window, N = 2**LOG2_SAMPLES
// OUT_BITS      2*N_BITS+2*LOG2_SAMPLES+1  derived (localparam), signed covariance width
// PORTS
// clk       in   1                      clock, rising edge
// rst       in   1                      asynchronous, active-low reset
// start     in   1                      begin a new window (accepted in IDLE or DONE only)
// abort     in   1                      synchronous abandon of current window
// in_valid  in   1                      sample vector valid
// in_ready  out  1                      block accepts sample (1 only in ACCUM)
// sample    in   N_BITS x N_CH signed   one sample per channel
// sum_out   out  (N_BITS+LOG2_SAMPLES) x N_CH signed   S1[i], registered at window end
// cov_out   out  OUT_BITS x N_CH x N_CH signed          N*Sigma, symmetric
// busy      out  1                      1 in ACCUM or FINAL
// done      out  1                      level, 1 in DONE
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; S1, S2, beat counter, element index, sum_out, cov_out all 0;
//   in_ready=busy=done=0. Reset applied mid-window discards that window.
// - FSM: IDLE -start-> ACCUM (clear S1/S2/counter); ACCUM -(Nth accepted beat)-> FINAL;
//   FINAL -(last element written)-> DONE; DONE -start-> ACCUM (same clearing); DONE holds otherwise.
// - abort=1 in any state: next state IDLE, accumulators cleared, cov_out/sum_out unchanged.
//   abort has priority over start and over a beat in the same cycle.
// - start is ignored in ACCUM and FINAL.
// - Beat = in_valid & in_ready on a rising edge. Per beat: S1[i] += sample[i];
//   S2[i][j] += sample[i]*sample[j] for the upper triangle j >= i only.
//   in_valid gaps stall accumulation with no effect.
// - Widths: S1 is N_BITS+LOG2_SAMPLES; S2 is 2*N_BITS+LOG2_SAMPLES. No overflow is possible
//   by construction, and there is no saturation.
// - sum_out is loaded from S1 on the ACCUM->FINAL edge, using S1 including the final beat.
// - FINAL: one upper-triangle element per cycle, in row-major order (i=0..N_CH-1, j=i..N_CH-1),
//   so M = N_CH*(N_CH+1)/2 cycles.
//   - Each element computes (S2[i][j] << LOG2_SAMPLES) - S1[i]*S1[j] in OUT_BITS signed arithmetic.
//   - The result is written to both cov_out[i][j] and cov_out[j][i].
//   - The block uses one shared S1 product multiplier.
// - Latency: if the last beat is accepted at edge k, cov_out is complete and done=1 after edge k+M.
// - cov_out updates element-wise during FINAL. Consumers sample cov_out only while done=1.
//   cov_out then holds until the next FINAL or reset.
// - N_CH=1 is legal: M=1.
// TESTING
// - N_CH=2,L=2; start, beats (1,2),(3,4),(5,6),(7,8) -> sum_out=(16,20), cov_out=[[80,80],[80,80]],
//   done 3 cycles after last accept.
// - Same config; beats (-1,1),(1,-1),(-1,1),(1,-1) -> sum_out=(0,0), cov_out=[[16,-16],[-16,16]].
// - Extreme values: all samples -2**(N_BITS-1) for default parameters -> cov_out all 0, no overflow.
//   Alternating +/-max on channel 0 -> cov[0][0]=N*N*(2**(2*N_BITS-2)).
// - Random in_valid gaps (50%) -> results identical to gapless run; in_ready=0 outside ACCUM;
//   beats while in FINAL are not taken.
// - abort after 2 beats, then start with 4 fresh beats -> result matches fresh window only,
//   previous cov_out held until overwritten.
// - rst=0 mid-FINAL -> all outputs 0 immediately (async); start after release runs a clean window.
//   start asserted in ACCUM is ignored.

Source files
------------

// File: rtl/cov_stream_accumulate_if.sv
// Sample stream handshake for the covariance front end.
// The producer drives in_valid/sample; the accumulator answers with in_ready.
interface cov_stream_accumulate_if #(
    parameter int N_CH   = 8,
    parameter int N_BITS = 22
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [N_BITS-1:0] sample [N_CH];

    modport master (
        output in_valid,
        output sample,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  sample,
        output in_ready
    );
endinterface

// File: rtl/cov_stream_accumulate.sv
// Streaming covariance front end: accumulates S1/S2 over 2**LOG2_SAMPLES
// beats, then emits N*S2 - S1*S1^T one upper-triangle element per cycle.
module cov_stream_accumulate #(
    parameter int N_CH         = 8,
    parameter int N_BITS       = 22,
    parameter int LOG2_SAMPLES = 7,
    localparam int OUT_BITS    = 2*N_BITS+2*LOG2_SAMPLES+1,
    localparam int S1W         = N_BITS+LOG2_SAMPLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    cov_stream_accumulate_if.slave     sin,
    output logic signed [S1W-1:0]      sum_out [N_CH],
    output logic signed [OUT_BITS-1:0] cov_out [N_CH][N_CH],
    output logic                       busy,
    output logic                       done
);

    localparam int S2W = 2*N_BITS+LOG2_SAMPLES;
    localparam int PW  = 2*N_BITS;
    localparam int IW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CH-1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FINAL,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [S1W-1:0]      s1     [N_CH];
    logic signed [S1W-1:0]      s1_nxt [N_CH];
    logic signed [S2W-1:0]      s2     [N_CH][N_CH];
    logic signed [PW-1:0]       pp     [N_CH][N_CH];
    logic [LOG2_SAMPLES-1:0]    cnt;
    logic [IW-1:0]              ri, ci;
    logic                       rdy, beat, last_beat, last_el, clear;
    logic signed [OUT_BITS-1:0] op_a, op_b, s2_ext, elem;

    function automatic logic signed [PW-1:0] ext_p(
        input logic signed [N_BITS-1:0] v);
        return {{(PW-N_BITS){v[N_BITS-1]}}, v};
    endfunction

    function automatic logic signed [S1W-1:0] ext_s1(
        input logic signed [N_BITS-1:0] v);
        return {{(S1W-N_BITS){v[N_BITS-1]}}, v};
    endfunction

    function automatic logic signed [S2W-1:0] ext_s2(
        input logic signed [PW-1:0] v);
        return {{(S2W-PW){v[PW-1]}}, v};
    endfunction

    function automatic logic signed [OUT_BITS-1:0] ext_o1(
        input logic signed [S1W-1:0] v);
        return {{(OUT_BITS-S1W){v[S1W-1]}}, v};
    endfunction

    function automatic logic signed [OUT_BITS-1:0] ext_o2(
        input logic signed [S2W-1:0] v);
        return {{(OUT_BITS-S2W){v[S2W-1]}}, v};
    endfunction

    // abort wins over any beat presented in the same cycle
    assign beat      = sin.in_valid & (state == S_ACCUM) & ~abort;
    assign last_beat = beat & (&cnt);
    assign last_el   = (ri == LAST_IDX);
    assign clear     = abort |
                       (start & ((state == S_IDLE) | (state == S_DONE)));
    assign sin.in_ready = rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                rdy  = 1'b1;
                busy = 1'b1;
                if (last_beat) state_nxt = S_FINAL;
            end
            S_FINAL: begin
                busy = 1'b1;
                if (last_el) state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = S_ACCUM;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // per-beat products; lower triangle forced to zero
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            s1_nxt[i] = s1[i] + ext_s1(sin.sample[i]);
            for (int j = 0; j < N_CH; j++) begin
                pp[i][j] = '0;
                if (j >= i)
                    pp[i][j] = ext_p(sin.sample[i]) * ext_p(sin.sample[j]);
            end
        end
    end

    // shared finalisation datapath for element (ri, ci)
    always_comb begin
        op_a   = ext_o1(s1[ri]);
        op_b   = ext_o1(s1[ci]);
        s2_ext = ext_o2(s2[ri][ci]);
        elem   = (s2_ext <<< LOG2_SAMPLES) - op_a * op_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            ri  <= '0;
            ci  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                s1[i]      <= '0;
                sum_out[i] <= '0;
                for (int j = 0; j < N_CH; j++) begin
                    s2[i][j]      <= '0;
                    cov_out[i][j] <= '0;
                end
            end
        end else if (clear) begin
            cnt <= '0;
            ri  <= '0;
            ci  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                s1[i] <= '0;
                for (int j = 0; j < N_CH; j++)
                    s2[i][j] <= '0;
            end
        end else if (beat) begin
            cnt <= cnt + LOG2_SAMPLES'(1);
            ri  <= '0;
            ci  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                s1[i] <= s1_nxt[i];
                if (&cnt) sum_out[i] <= s1_nxt[i];
                for (int j = 0; j < N_CH; j++)
                    s2[i][j] <= s2[i][j] + ext_s2(pp[i][j]);
            end
        end else if (state == S_FINAL) begin
            cov_out[ri][ci] <= elem;
            cov_out[ci][ri] <= elem;
            if (ci == LAST_IDX) begin
                ri <= ri + IW'(1);
                ci <= ri + IW'(1);
            end else begin
                ci <= ci + IW'(1);
            end
        end
    end

endmodule
